// File: rtl/branch_pkg.sv
// branch_pkg
//   Shared branch definitions used by the decoder, the combinational decider
//   and the registered branch_resolve_unit.
//   - BR_* : 3-bit branch type codes (110/111 reserved, resolve as not taken)
//   - br_type_t : branch type field
//   - laneIdxW() : width of a lane index, never less than 1 bit
package branch_pkg;

  typedef logic [2:0] br_type_t;

  localparam br_type_t BR_BEQ  = 3'b000;
  localparam br_type_t BR_BNE  = 3'b001;
  localparam br_type_t BR_BLT  = 3'b010;
  localparam br_type_t BR_BGE  = 3'b011;
  localparam br_type_t BR_BLTU = 3'b100;
  localparam br_type_t BR_BGEU = 3'b101;

  function automatic int laneIdxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval
//   Combinational single-lane branch evaluation: full-width eq / signed-lt /
//   unsigned-lt compares followed by the branch type decode.
//   Ports:
//     brType : branch type code (br_type_t)
//     rs1    : operand 1, XLEN bits
//     rs2    : operand 2, XLEN bits
//     dec    : resolved direction (1 = taken)
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  br_type_t          brType,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic              dec
);

  logic isEq;
  logic isSlt;
  logic isUlt;

  assign isEq  = (rs1 == rs2);
  assign isSlt = ($signed(rs1) < $signed(rs2));
  assign isUlt = (rs1 < rs2);

  always_comb begin
    dec = 1'b0;
    unique case (brType)
      BR_BEQ:  dec = isEq;
      BR_BNE:  dec = ~isEq;
      BR_BLT:  dec = isSlt;
      BR_BGE:  dec = ~isSlt;
      BR_BLTU: dec = isUlt;
      BR_BGEU: dec = ~isUlt;
      default: dec = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Registered multi-lane branch resolver. Each bundle carries up to NUM_LANES
//   branches (lane 0 oldest). Outcomes are compared with the front-end
//   prediction, lanes younger than the oldest mispredict are killed, and the
//   result is held in a single valid/ready output stage. Per-lane saturating
//   mispredict counters are updated when a result bundle is accepted.
//   Ports:
//     clk, rst_n         : clock (rising edge), async active-low reset
//     mode               : 1 = unified (lane 0 only), 0 = split (all lanes)
//     in_valid/in_ready  : input bundle handshake (per-lane valid)
//     branch_type        : per-lane 3-bit type, lane i at [3i+2:3i]
//     rs1, rs2           : per-lane XLEN operands
//     pred_taken         : per-lane front-end prediction
//     out_valid/out_ready: output bundle handshake
//     out_lane_valid     : lane carries a live resolved branch
//     taken, mispredict  : per-lane resolved direction / mispredict flag
//     flush, flush_lane  : redirect request and oldest mispredicting lane
//     clear_stats        : synchronous clear of all counters
//     mispredict_cnt     : per-lane CNT_W-bit saturating counters
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int XLEN      = 32,
  parameter int CNT_W     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 mode,
  input  logic [NUM_LANES-1:0]                 in_valid,
  output logic                                 in_ready,
  input  logic [3*NUM_LANES-1:0]               branch_type,
  input  logic [XLEN*NUM_LANES-1:0]            rs1,
  input  logic [XLEN*NUM_LANES-1:0]            rs2,
  input  logic [NUM_LANES-1:0]                 pred_taken,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_LANES-1:0]                 out_lane_valid,
  output logic [NUM_LANES-1:0]                 taken,
  output logic [NUM_LANES-1:0]                 mispredict,
  output logic                                 flush,
  output logic [laneIdxW(NUM_LANES)-1:0]       flush_lane,
  input  logic                                 clear_stats,
  output logic [CNT_W*NUM_LANES-1:0]           mispredict_cnt
);

  localparam int LIDX_W = laneIdxW(NUM_LANES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_LANES-1:0] effValid;
  logic [NUM_LANES-1:0] laneDec;
  logic                 inFire;
  logic                 outAccept;

  logic [NUM_LANES-1:0] nxtLaneValid;
  logic [NUM_LANES-1:0] nxtTaken;
  logic [NUM_LANES-1:0] nxtMiss;
  logic [LIDX_W-1:0]    nxtFlushLane;
  logic                 missSeen;

  logic                 outValidQ;
  logic [NUM_LANES-1:0] laneValidQ;
  logic [NUM_LANES-1:0] takenQ;
  logic [NUM_LANES-1:0] missQ;
  logic [LIDX_W-1:0]    flushLaneQ;
  logic [CNT_W-1:0]     cntQ [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    branch_cond_eval #(
      .XLEN (XLEN)
    ) uEval (
      .brType (branch_type[3*g +: 3]),
      .rs1    (rs1[XLEN*g +: XLEN]),
      .rs2    (rs2[XLEN*g +: XLEN]),
      .dec    (laneDec[g])
    );

    assign mispredict_cnt[CNT_W*g +: CNT_W] = cntQ[g];
  end

  // Unified mode keeps only lane 0; upper lanes are invisible to the unit.
  always_comb begin
    effValid = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      effValid[i] = in_valid[i] & (~mode | (i == 0));
    end
  end

  assign in_ready  = ~outValidQ | out_ready;
  assign inFire    = in_ready & (|effValid);
  assign outAccept = outValidQ & out_ready;

  // Walk lanes oldest-first; once a mispredict is found every younger lane
  // is dropped, so at most one lane can ever carry the mispredict flag.
  always_comb begin
    nxtLaneValid = '0;
    nxtTaken     = '0;
    nxtMiss      = '0;
    nxtFlushLane = '0;
    missSeen     = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!missSeen && effValid[i]) begin
        nxtLaneValid[i] = 1'b1;
        nxtTaken[i]     = laneDec[i];
        if (laneDec[i] != pred_taken[i]) begin
          nxtMiss[i]   = 1'b1;
          nxtFlushLane = LIDX_W'(i);
          missSeen     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValidQ  <= 1'b0;
      laneValidQ <= '0;
      takenQ     <= '0;
      missQ      <= '0;
      flushLaneQ <= '0;
    end else if (inFire) begin
      outValidQ  <= 1'b1;
      laneValidQ <= nxtLaneValid;
      takenQ     <= nxtTaken;
      missQ      <= nxtMiss;
      flushLaneQ <= nxtFlushLane;
    end else if (out_ready) begin
      // Drained with nothing new: return lane outputs to their idle zeros.
      outValidQ  <= 1'b0;
      laneValidQ <= '0;
      takenQ     <= '0;
      missQ      <= '0;
      flushLaneQ <= '0;
    end
  end

  // Counters are keyed off the accepted bundle (the one leaving this cycle),
  // not the one being captured. Clear has priority over any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) cntQ[i] <= '0;
    end else if (clear_stats) begin
      for (int i = 0; i < NUM_LANES; i++) cntQ[i] <= '0;
    end else if (outAccept) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (missQ[i] && (cntQ[i] != CNT_MAX)) cntQ[i] <= cntQ[i] + 1'b1;
      end
    end
  end

  assign out_valid      = outValidQ;
  assign out_lane_valid = laneValidQ;
  assign taken          = takenQ;
  assign mispredict     = missQ;
  assign flush_lane     = flushLaneQ;
  assign flush          = outValidQ & (|missQ);

endmodule
